zpu_sd_ctrl: RTL and testbench
==============================

ZPU_SD_CTRL -- requirements
Module: zpu_sd_ctrl

Interface
REQ-001 Parameter ACK_TIMEOUT, default 50_000_000, is the number of clk_sys cycles allowed from request assertion to the falling edge of sd_ack.
REQ-002 clk_sys  in  1  single system clock; all logic is on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 zpu_lba_sel  in  1  when high, data writes target the LBA register and zpu_rdata returns the file size.
REQ-005 zpu_block_rd / zpu_block_wr  in  1 each  level strobes; a rising edge requests a sector read / sector write.
REQ-006 zpu_io_wr  in  1  clears the buffer pointer.
REQ-007 zpu_data_wr / zpu_data_rd  in  1 each  ZPU data-port write / read strobes.
REQ-008 zpu_wdata  in  32  ZPU write data.
REQ-009 zpu_rdata  out  32  file size when zpu_lba_sel=1, otherwise {24'b0, buf_q}.
REQ-010 zpu_status  out  8  bit 0 io_done, bit 1 mounted toggle, bits 4:2 fileno, bits 6:5 filetype, bit 7 readonly.
REQ-011 zpu_error  out  1  sticky timeout flag.
REQ-012 sd_lba  out  32;  sd_rd, sd_wr  out  1 each;  sd_ack  in  1  HPS sector handshake.
REQ-013 img_mounted  in  1;  img_size  in  32;  ioctl_index  in  8  mount information.
REQ-014 buf_addr  out  9;  buf_wr  out  1;  buf_q  in  8  ZPU-side port of the 512-byte sector buffer.

Function
REQ-015 The FSM SHALL have four states: IDLE, REQ, XFER, DONE.
REQ-016 IDLE -> REQ on a rising edge of block_rd (sets sd_rd) or block_wr (sets sd_wr); io_done clears in the same cycle.
REQ-017 If both rising edges arrive in the same cycle, the read SHALL win and the write SHALL be dropped.
REQ-018 REQ -> XFER on sd_ack=1; sd_rd and sd_wr clear in that cycle.
REQ-019 XFER -> DONE on sd_ack=0.
REQ-020 DONE SHALL set io_done for the ZPU and return to IDLE in the following cycle.
REQ-021 Block strobes received outside IDLE SHALL be ignored, and their edges SHALL NOT be queued.
REQ-022 A timeout counter SHALL run in REQ and XFER; on reaching ACK_TIMEOUT it SHALL clear sd_rd/sd_wr, set zpu_error and io_done, and go to IDLE.
REQ-023 zpu_error SHALL clear on the next accepted block request.
REQ-024 Data write: zpu_data_wr passes through a 2-flop stage; a rising edge at the second stage writes zpu_wdata to sd_lba if zpu_lba_sel=1, otherwise it produces a 1-cycle buf_wr pulse and buf_addr increments on the cycle after that pulse.
REQ-025 Data read: buf_addr SHALL increment one cycle after a falling edge of zpu_data_rd.
REQ-026 buf_addr SHALL wrap from 511 to 0.
REQ-027 When zpu_io_wr coincides with an increment, zpu_io_wr wins and buf_addr becomes 0.
REQ-028 On a rising edge of img_mounted, in one cycle: fileno=0, filetype=ioctl_index[7:6], readonly=1, filesize=img_size, and the mounted bit toggles.
REQ-029 zpu_rdata SHALL be combinational from the registers and buf_q, with no added latency.

Reset
REQ-030 Reset SHALL produce: FSM=IDLE, sd_rd=sd_wr=0, buf_wr=0, buf_addr=0, io_done=0, zpu_error=0, timeout counter=0, edge-detect history=0, mounted=|img_size.
REQ-031 sd_lba, fileno, filetype, readonly and filesize SHALL retain their values through reset.
REQ-032 Reset asserted during REQ or XFER SHALL abort the transfer immediately, with no io_done pulse.

Configuration
REQ-033 With ZPU_SD_WRITE_EN defined, sector writes SHALL be supported as specified above.
REQ-034 With ZPU_SD_WRITE_EN undefined, block_wr SHALL be ignored, sd_wr SHALL be tied to 0, and readonly SHALL be forced to 1.

Structure
REQ-035 Package zpu_sd_pkg SHALL hold the FSM state enum, the zpu_status bit-position constants and the buffer depth constant (512).
REQ-036 A single sub-module, zpu_sd_edge, SHALL provide the registered rise/fall detector and SHALL be instantiated once per strobe.

Verification
REQ-037 Read: write LBA 0x00001234 with lba_sel=1, raise block_rd; HPS raises sd_ack after 5 cycles and holds it 10 cycles. Required: sd_lba=0x1234, sd_rd high until ack, io_done=0 during the transfer and 1 after ack falls.
REQ-038 block_rd and block_wr rising in the same cycle: only sd_rd asserts. A block_wr edge during XFER: no sd_wr and no second transfer.
REQ-039 Leave sd_ack low with ACK_TIMEOUT=100: after 100 cycles sd_rd=0, zpu_error=1, io_done=1, FSM=IDLE.
REQ-040 Buffer pointer: 512 data writes make buf_addr wrap to 0; an io_wr coinciding with a data_rd falling edge leaves buf_addr=0.
REQ-041 Mount img_size=0x2000 with ioctl_index=0x80: filetype=2, filesize=0x2000, the mounted bit toggles; a following reset gives mounted=1.
REQ-042 With ZPU_SD_WRITE_EN undefined: a block_wr edge keeps sd_wr=0, FSM stays in IDLE, and io_done is unchanged.

Source files
------------

// File: rtl/zpu_sd_pkg.sv
// Shared types and constants for the ZPU SD sector controller.
package zpu_sd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } sd_state_t;

  localparam int BUF_DEPTH = 512;
  localparam int BUF_AW    = $clog2(BUF_DEPTH);

  localparam int STAT_IO_DONE      = 0;
  localparam int STAT_MOUNTED      = 1;
  localparam int STAT_FILENO_LSB   = 2;
  localparam int STAT_FILETYPE_LSB = 5;
  localparam int STAT_READONLY     = 7;

endpackage

// File: rtl/zpu_sd_ctrl_if.sv
// ZPU-side register/strobe port of the SD sector controller.
interface zpu_sd_ctrl_if;

  logic        zpu_lba_sel;
  logic        zpu_block_rd;
  logic        zpu_block_wr;
  logic        zpu_io_wr;
  logic        zpu_data_wr;
  logic        zpu_data_rd;
  logic [31:0] zpu_wdata;
  logic [31:0] zpu_rdata;
  logic [7:0]  zpu_status;
  logic        zpu_error;

  modport master (
    output zpu_lba_sel, zpu_block_rd, zpu_block_wr, zpu_io_wr,
           zpu_data_wr, zpu_data_rd, zpu_wdata,
    input  zpu_rdata, zpu_status, zpu_error
  );

  modport slave (
    input  zpu_lba_sel, zpu_block_rd, zpu_block_wr, zpu_io_wr,
           zpu_data_wr, zpu_data_rd, zpu_wdata,
    output zpu_rdata, zpu_status, zpu_error
  );

endinterface

// File: rtl/zpu_sd_edge.sv
// Registered rise/fall detector with STAGES flops ahead of the history flop.
module zpu_sd_edge #(
  parameter int STAGES = 1
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic [STAGES:0] pipe;

  always_ff @(posedge clk_sys) begin
    if (reset) pipe <= '0;
    else       pipe <= {pipe[STAGES-1:0], sig};
  end

  assign rise =  pipe[STAGES-1] & ~pipe[STAGES];
  assign fall = ~pipe[STAGES-1] &  pipe[STAGES];

endmodule

// File: rtl/zpu_sd_ctrl.sv
// ZPU <-> HPS SD sector controller: request FSM, ack timeout, buffer pointer, mount info.
// Sector writes are built only when ZPU_SD_WRITE_EN is defined.
module zpu_sd_ctrl
  import zpu_sd_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 50_000_000
) (
  input  logic              clk_sys,
  input  logic              reset,
  zpu_sd_ctrl_if.slave      zpu,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  input  logic              img_mounted,
  input  logic [31:0]       img_size,
  input  logic [7:0]        ioctl_index,
  output logic [BUF_AW-1:0] buf_addr,
  output logic              buf_wr,
  input  logic [7:0]        buf_q
);

  // state | meaning
  // IDLE  | waiting for a block_rd / block_wr rising edge
  // REQ   | sd_rd or sd_wr asserted, waiting for sd_ack high
  // XFER  | HPS moving the sector, waiting for sd_ack low
  // DONE  | one cycle to raise io_done, then back to IDLE

  localparam logic [31:0] TMO_LOAD = 32'(ACK_TIMEOUT - 1);

  sd_state_t   state, state_nxt;
  logic        rd_rise, wr_rise, dwr_rise, drd_fall, mnt_rise;
  logic        rd_fall, wr_fall, dwr_fall, drd_rise, mnt_fall;
  logic        wr_req;
  logic        accept_rd, accept_wr, ack_seen, timeout, done;
  logic [31:0] tmo_cnt;
  logic        sd_wr_q, io_done, zpu_err, mounted;
  logic [2:0]  fileno;
  logic [1:0]  filetype;
  logic        readonly_q, ro_bit;
  logic [31:0] filesize;
  logic [7:0]  status;
  logic        unused_sig;

  zpu_sd_edge #(.STAGES(1)) u_rd_edge  (.clk_sys(clk_sys), .reset(reset), .sig(zpu.zpu_block_rd),
                                        .rise(rd_rise), .fall(rd_fall));
  zpu_sd_edge #(.STAGES(1)) u_wr_edge  (.clk_sys(clk_sys), .reset(reset), .sig(zpu.zpu_block_wr),
                                        .rise(wr_rise), .fall(wr_fall));
  zpu_sd_edge #(.STAGES(2)) u_dwr_edge (.clk_sys(clk_sys), .reset(reset), .sig(zpu.zpu_data_wr),
                                        .rise(dwr_rise), .fall(dwr_fall));
  zpu_sd_edge #(.STAGES(1)) u_drd_edge (.clk_sys(clk_sys), .reset(reset), .sig(zpu.zpu_data_rd),
                                        .rise(drd_rise), .fall(drd_fall));
  zpu_sd_edge #(.STAGES(1)) u_mnt_edge (.clk_sys(clk_sys), .reset(reset), .sig(img_mounted),
                                        .rise(mnt_rise), .fall(mnt_fall));

`ifdef ZPU_SD_WRITE_EN
  assign wr_req = wr_rise;
  assign sd_wr  = sd_wr_q;
  assign ro_bit = readonly_q;
`else
  assign wr_req = 1'b0;
  assign sd_wr  = 1'b0;
  assign ro_bit = 1'b1;
`endif

  assign unused_sig = &{1'b0, rd_fall, wr_fall, dwr_fall, drd_rise, mnt_fall,
                        wr_rise, sd_wr_q, readonly_q};

  always_comb begin
    state_nxt = state;
    accept_rd = 1'b0;
    accept_wr = 1'b0;
    ack_seen  = 1'b0;
    timeout   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        // read wins a same-cycle collision; edges outside IDLE are simply lost
        if (rd_rise) begin
          accept_rd = 1'b1;
          state_nxt = REQ;
        end else if (wr_req) begin
          accept_wr = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (tmo_cnt == '0) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end else if (sd_ack) begin
          ack_seen  = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (tmo_cnt == '0) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end else if (!sd_ack) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= IDLE;
      sd_rd   <= 1'b0;
      sd_wr_q <= 1'b0;
      io_done <= 1'b0;
      zpu_err <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept_rd || accept_wr) begin
        sd_rd   <= accept_rd;
        sd_wr_q <= accept_wr;
        io_done <= 1'b0;
        zpu_err <= 1'b0;
        tmo_cnt <= TMO_LOAD;
      end else if ((state == REQ || state == XFER) && tmo_cnt != '0) begin
        tmo_cnt <= tmo_cnt - 32'd1;
      end
      if (ack_seen || timeout) begin
        sd_rd   <= 1'b0;
        sd_wr_q <= 1'b0;
      end
      if (timeout) begin
        zpu_err <= 1'b1;
        io_done <= 1'b1;
      end
      if (done) io_done <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      buf_addr <= '0;
      buf_wr   <= 1'b0;
      mounted  <= |img_size;
    end else begin
      buf_wr <= dwr_rise & ~zpu.zpu_lba_sel;
      if (zpu.zpu_io_wr)            buf_addr <= '0;
      else if (buf_wr || drd_fall)  buf_addr <= buf_addr + 1'b1;
      if (mnt_rise) mounted <= ~mounted;
    end
  end

  // Image/LBA registers deliberately survive reset
  always_ff @(posedge clk_sys) begin
    if (!reset && dwr_rise && zpu.zpu_lba_sel) sd_lba <= zpu.zpu_wdata;
    if (!reset && mnt_rise) begin
      fileno     <= 3'd0;
      filetype   <= ioctl_index[7:6];
      readonly_q <= 1'b1;
      filesize   <= img_size;
    end
  end

  always_comb begin
    status                                = '0;
    status[STAT_IO_DONE]                  = io_done;
    status[STAT_MOUNTED]                  = mounted;
    status[STAT_FILENO_LSB +: 3]          = fileno;
    status[STAT_FILETYPE_LSB +: 2]        = filetype;
    status[STAT_READONLY]                 = ro_bit;
  end

  assign zpu.zpu_status = status;
  assign zpu.zpu_error  = zpu_err;
  assign zpu.zpu_rdata  = zpu.zpu_lba_sel ? filesize : {24'b0, buf_q};

endmodule

// File: tb/tb_zpu_sd_ctrl.sv
// Directed self-checking bench for zpu_sd_ctrl (ACK_TIMEOUT shortened to 100).
module tb_zpu_sd_ctrl;
  import zpu_sd_pkg::*;

  logic        clk_sys;
  logic        reset;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack;
  logic        img_mounted;
  logic [31:0] img_size;
  logic [7:0]  ioctl_index;
  logic [8:0]  buf_addr;
  logic        buf_wr;
  logic [7:0]  buf_q;

  int checks = 0;
  int errors = 0;

  zpu_sd_ctrl_if z ();

  zpu_sd_ctrl #(.ACK_TIMEOUT(100)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .zpu         (z.slave),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .img_mounted (img_mounted),
    .img_size    (img_size),
    .ioctl_index (ioctl_index),
    .buf_addr    (buf_addr),
    .buf_wr      (buf_wr),
    .buf_q       (buf_q)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st();
    return 32'(dut.state);
  endfunction

  initial begin
    reset = 1'b1;
    sd_ack = 1'b0;
    img_mounted = 1'b0;
    img_size = 32'h0;
    ioctl_index = 8'h0;
    buf_q = 8'h0;
    z.zpu_lba_sel = 1'b0;
    z.zpu_block_rd = 1'b0;
    z.zpu_block_wr = 1'b0;
    z.zpu_io_wr = 1'b0;
    z.zpu_data_wr = 1'b0;
    z.zpu_data_rd = 1'b0;
    z.zpu_wdata = 32'h0;
    step(3);
    reset = 1'b0;

    // reset state
    chk("rst_sd_rd", {31'b0, sd_rd}, 32'd0);
    chk("rst_sd_wr", {31'b0, sd_wr}, 32'd0);
    chk("rst_buf_addr", {23'b0, buf_addr}, 32'd0);
    chk("rst_buf_wr", {31'b0, buf_wr}, 32'd0);
    chk("rst_io_done", {31'b0, z.zpu_status[0]}, 32'd0);
    chk("rst_error", {31'b0, z.zpu_error}, 32'd0);
    chk("rst_mounted", {31'b0, z.zpu_status[1]}, 32'd0);
    chk("rst_state", st(), 32'(IDLE));

    // LBA write through the 2-flop data path
    z.zpu_lba_sel = 1'b1;
    z.zpu_wdata = 32'h0000_1234;
    z.zpu_data_wr = 1'b1;
    step(1);
    z.zpu_data_wr = 1'b0;
    step(4);
    chk("lba_write", sd_lba, 32'h0000_1234);
    chk("lba_no_buf_wr", {23'b0, buf_addr}, 32'd0);

    // sector read: ack after 5 cycles, held 10 cycles
    z.zpu_block_rd = 1'b1;
    step(2);
    chk("rd_sd_rd_set", {31'b0, sd_rd}, 32'd1);
    chk("rd_io_done_clr", {31'b0, z.zpu_status[0]}, 32'd0);
    step(3);
    chk("rd_sd_rd_hold", {31'b0, sd_rd}, 32'd1);
    sd_ack = 1'b1;
    step(1);
    chk("rd_sd_rd_clr_on_ack", {31'b0, sd_rd}, 32'd0);
    chk("rd_state_xfer", st(), 32'(XFER));
    step(9);
    chk("rd_io_done_during", {31'b0, z.zpu_status[0]}, 32'd0);
    sd_ack = 1'b0;
    step(2);
    chk("rd_io_done_after", {31'b0, z.zpu_status[0]}, 32'd1);
    chk("rd_state_idle", st(), 32'(IDLE));
    chk("rd_error", {31'b0, z.zpu_error}, 32'd0);
    z.zpu_block_rd = 1'b0;
    step(2);

    // simultaneous rd/wr edges: read wins
    z.zpu_block_rd = 1'b1;
    z.zpu_block_wr = 1'b1;
    step(2);
    chk("both_sd_rd", {31'b0, sd_rd}, 32'd1);
    chk("both_sd_wr", {31'b0, sd_wr}, 32'd0);
    sd_ack = 1'b1;
    step(1);
    z.zpu_block_rd = 1'b0;
    z.zpu_block_wr = 1'b0;
    step(1);
    z.zpu_block_wr = 1'b1;
    step(2);
    chk("xfer_wr_edge_sd_wr", {31'b0, sd_wr}, 32'd0);
    chk("xfer_wr_edge_state", st(), 32'(XFER));
    sd_ack = 1'b0;
    step(2);
    chk("both_done", {31'b0, z.zpu_status[0]}, 32'd1);
    step(2);
    chk("no_second_xfer_state", st(), 32'(IDLE));
    chk("no_second_xfer_sd_wr", {31'b0, sd_wr}, 32'd0);
    z.zpu_block_wr = 1'b0;
    step(2);

`ifdef ZPU_SD_WRITE_EN
    z.zpu_block_wr = 1'b1;
    step(2);
    chk("wr_sd_wr_set", {31'b0, sd_wr}, 32'd1);
    chk("wr_io_done_clr", {31'b0, z.zpu_status[0]}, 32'd0);
    sd_ack = 1'b1;
    step(1);
    chk("wr_sd_wr_clr", {31'b0, sd_wr}, 32'd0);
    sd_ack = 1'b0;
    step(2);
    chk("wr_io_done", {31'b0, z.zpu_status[0]}, 32'd1);
    z.zpu_block_wr = 1'b0;
    step(2);
`else
    z.zpu_block_wr = 1'b1;
    step(3);
    chk("wdis_sd_wr", {31'b0, sd_wr}, 32'd0);
    chk("wdis_state", st(), 32'(IDLE));
    chk("wdis_io_done", {31'b0, z.zpu_status[0]}, 32'd1);
    chk("wdis_readonly", {31'b0, z.zpu_status[7]}, 32'd1);
    z.zpu_block_wr = 1'b0;
    step(2);
`endif

    // ack timeout: sd_ack never rises
    z.zpu_block_rd = 1'b1;
    step(2);
    chk("tmo_sd_rd_set", {31'b0, sd_rd}, 32'd1);
    step(99);
    chk("tmo_before_sd_rd", {31'b0, sd_rd}, 32'd1);
    chk("tmo_before_error", {31'b0, z.zpu_error}, 32'd0);
    step(1);
    chk("tmo_sd_rd", {31'b0, sd_rd}, 32'd0);
    chk("tmo_error", {31'b0, z.zpu_error}, 32'd1);
    chk("tmo_io_done", {31'b0, z.zpu_status[0]}, 32'd1);
    chk("tmo_state", st(), 32'(IDLE));
    z.zpu_block_rd = 1'b0;
    step(2);

    // next accepted request clears the error; reset then aborts it
    z.zpu_block_rd = 1'b1;
    step(2);
    chk("err_clr", {31'b0, z.zpu_error}, 32'd0);
    chk("err_clr_sd_rd", {31'b0, sd_rd}, 32'd1);
    reset = 1'b1;
    z.zpu_block_rd = 1'b0;
    step(1);
    reset = 1'b0;
    step(1);
    chk("abort_sd_rd", {31'b0, sd_rd}, 32'd0);
    chk("abort_io_done", {31'b0, z.zpu_status[0]}, 32'd0);
    chk("abort_state", st(), 32'(IDLE));
    chk("abort_lba_kept", sd_lba, 32'h0000_1234);

    // buffer pointer: 512 writes wrap to 0
    z.zpu_lba_sel = 1'b0;
    for (int i = 0; i < 511; i++) begin
      z.zpu_data_wr = 1'b1;
      step(1);
      z.zpu_data_wr = 1'b0;
      step(1);
    end
    step(4);
    chk("buf_addr_511", {23'b0, buf_addr}, 32'd511);
    z.zpu_data_wr = 1'b1;
    step(1);
    z.zpu_data_wr = 1'b0;
    step(2);
    chk("buf_wr_pulse", {31'b0, buf_wr}, 32'd1);
    chk("buf_addr_pre_wrap", {23'b0, buf_addr}, 32'd511);
    step(1);
    chk("buf_wr_end", {31'b0, buf_wr}, 32'd0);
    chk("buf_addr_wrap", {23'b0, buf_addr}, 32'd0);

    // data read: increment one cycle after the falling edge
    z.zpu_data_rd = 1'b1;
    step(2);
    z.zpu_data_rd = 1'b0;
    step(1);
    chk("rd_inc_wait", {23'b0, buf_addr}, 32'd0);
    step(1);
    chk("rd_inc", {23'b0, buf_addr}, 32'd1);
    z.zpu_data_rd = 1'b1;
    step(2);
    z.zpu_data_rd = 1'b0;
    step(1);
    z.zpu_io_wr = 1'b1;
    step(1);
    z.zpu_io_wr = 1'b0;
    chk("io_wr_wins", {23'b0, buf_addr}, 32'd0);
    step(2);
    chk("io_wr_wins_hold", {23'b0, buf_addr}, 32'd0);

    // rdata mux is combinational
    buf_q = 8'hA5;
    #1;
    chk("rdata_buf_a5", z.zpu_rdata, 32'h0000_00A5);
    buf_q = 8'h3C;
    #1;
    chk("rdata_buf_3c", z.zpu_rdata, 32'h0000_003C);

    // mount
    img_size = 32'h0000_2000;
    ioctl_index = 8'h80;
    img_mounted = 1'b1;
    step(2);
    z.zpu_lba_sel = 1'b1;
    #1;
    chk("mnt_toggle", {31'b0, z.zpu_status[1]}, 32'd1);
    chk("mnt_filetype", {30'b0, z.zpu_status[6:5]}, 32'd2);
    chk("mnt_fileno", {29'b0, z.zpu_status[4:2]}, 32'd0);
    chk("mnt_readonly", {31'b0, z.zpu_status[7]}, 32'd1);
    chk("mnt_filesize", z.zpu_rdata, 32'h0000_2000);
    img_mounted = 1'b0;
    step(2);
    img_mounted = 1'b1;
    step(2);
    chk("mnt_toggle_back", {31'b0, z.zpu_status[1]}, 32'd0);
    img_mounted = 1'b0;
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
    chk("rst_mounted_size", {31'b0, z.zpu_status[1]}, 32'd1);
    chk("rst_filesize_kept", z.zpu_rdata, 32'h0000_2000);
    chk("rst_filetype_kept", {30'b0, z.zpu_status[6:5]}, 32'd2);
    chk("rst_io_done_final", {31'b0, z.zpu_status[0]}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
